// File: rtl/skipjack_block_packer.sv
`timescale 1ns/1ps
// skipjack_block_packer
// Packs bytes from the UART receive AXI-Stream into 64-bit plaintext blocks
// for the Skipjack cipher. The first byte received lands in bits [63:56].
// A partial block that sits idle for TIMEOUT_CYCLES clocks is either padded
// out with PAD_BYTE and sent, or discarded, depending on PAD_ENABLE.
//
// Ports:
//   clk            single clock
//   rst_n          synchronous active-low reset
//   s_axis_tdata   byte from the UART receiver
//   s_axis_tvalid  byte valid
//   s_axis_tready  packer can accept a byte (high only while collecting)
//   m_axis_tdata   64-bit block to the cipher
//   m_axis_tvalid  block valid
//   m_axis_tready  cipher accepts the block
//   byte_cnt       bytes held in the current block, 0..8
//   pad_count      blocks sent with padding (saturating)
//   drop_count     partial blocks discarded (saturating)
module skipjack_block_packer #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter bit          PAD_ENABLE     = 1'b1,
  parameter logic [7:0]  PAD_BYTE       = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [63:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [3:0]  byte_cnt,
  output logic [15:0] pad_count,
  output logic [15:0] drop_count
);

  localparam int unsigned IDLE_W      = 24;
  localparam int unsigned CNT_W       = 4;
  localparam int unsigned STAT_W      = 16;
  localparam int unsigned BLOCK_BYTES = 8;

  localparam logic [IDLE_W-1:0] TIMEOUT_LIM = IDLE_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  LAST_CNT    = CNT_W'(BLOCK_BYTES - 1);
  localparam logic [STAT_W-1:0] STAT_MAX    = '1;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    PAD     = 2'd1,
    OUT     = 2'd2
  } state_t;

  state_t            state;
  logic [IDLE_W-1:0] idle_cnt;

  logic byte_acc_c;
  logic partial_c;
  logic timeout_c;

  // Handshake and timeout qualifiers for the current cycle.
  always_comb begin
    byte_acc_c = s_axis_tvalid & s_axis_tready;
    partial_c  = (state == COLLECT) && (byte_cnt != '0) && (byte_cnt <= LAST_CNT);
    // Fires on the cycle the idle counter would reach the limit; an accepted
    // byte in that same cycle takes priority.
    timeout_c  = partial_c && !byte_acc_c &&
                 ((idle_cnt + IDLE_W'(1)) == TIMEOUT_LIM);
  end

  // Packer state machine with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= COLLECT;
      idle_cnt      <= '0;
      byte_cnt      <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      s_axis_tready <= 1'b1;
      pad_count     <= '0;
      drop_count    <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (byte_acc_c) begin
            m_axis_tdata <= {m_axis_tdata[55:0], s_axis_tdata};
            byte_cnt     <= byte_cnt + CNT_W'(1);
            idle_cnt     <= '0;
            if (byte_cnt == LAST_CNT) begin
              state         <= OUT;
              m_axis_tvalid <= 1'b1;
              s_axis_tready <= 1'b0;
            end
          end else if (partial_c) begin
            if (timeout_c) begin
              idle_cnt <= '0;
              if (PAD_ENABLE != 1'b0) begin
                state         <= PAD;
                s_axis_tready <= 1'b0;
              end else begin
                byte_cnt <= '0;
                if (drop_count != STAT_MAX) begin
                  drop_count <= drop_count + STAT_W'(1);
                end
              end
            end else begin
              idle_cnt <= idle_cnt + IDLE_W'(1);
            end
          end
        end

        // One fill byte per cycle until the block is full.
        PAD: begin
          m_axis_tdata <= {m_axis_tdata[55:0], PAD_BYTE};
          byte_cnt     <= byte_cnt + CNT_W'(1);
          if (byte_cnt == LAST_CNT) begin
            state         <= OUT;
            m_axis_tvalid <= 1'b1;
            if (pad_count != STAT_MAX) begin
              pad_count <= pad_count + STAT_W'(1);
            end
          end
        end

        // Block held stable until the cipher takes it.
        OUT: begin
          if (m_axis_tready) begin
            state         <= COLLECT;
            m_axis_tvalid <= 1'b0;
            s_axis_tready <= 1'b1;
            byte_cnt      <= '0;
            idle_cnt      <= '0;
          end
        end

        default: begin
          state         <= COLLECT;
          m_axis_tvalid <= 1'b0;
          s_axis_tready <= 1'b1;
          byte_cnt      <= '0;
          idle_cnt      <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_skipjack_block_packer.sv
`timescale 1ns/1ps
// Bench for skipjack_block_packer: instance 0 pads partial blocks with 8'hAA,
// instance 1 discards them; both use a 16-cycle idle timeout.
module tb_skipjack_block_packer;

  localparam int TO = 16;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n    [2];
  logic [7:0]  s_tdata  [2];
  logic        s_tvalid [2];
  logic        s_tready [2];
  logic [63:0] m_tdata  [2];
  logic        m_tvalid [2];
  logic        m_tready [2];
  logic [3:0]  byte_cnt [2];
  logic [15:0] pad_cnt  [2];
  logic [15:0] drop_cnt [2];

  skipjack_block_packer #(.TIMEOUT_CYCLES(TO), .PAD_ENABLE(1'b1), .PAD_BYTE(8'hAA)) u_pad (
    .clk(clk), .rst_n(rst_n[0]),
    .s_axis_tdata(s_tdata[0]), .s_axis_tvalid(s_tvalid[0]), .s_axis_tready(s_tready[0]),
    .m_axis_tdata(m_tdata[0]), .m_axis_tvalid(m_tvalid[0]), .m_axis_tready(m_tready[0]),
    .byte_cnt(byte_cnt[0]), .pad_count(pad_cnt[0]), .drop_count(drop_cnt[0]));

  skipjack_block_packer #(.TIMEOUT_CYCLES(TO), .PAD_ENABLE(1'b0), .PAD_BYTE(8'hAA)) u_drop (
    .clk(clk), .rst_n(rst_n[1]),
    .s_axis_tdata(s_tdata[1]), .s_axis_tvalid(s_tvalid[1]), .s_axis_tready(s_tready[1]),
    .m_axis_tdata(m_tdata[1]), .m_axis_tvalid(m_tvalid[1]), .m_axis_tready(m_tready[1]),
    .byte_cnt(byte_cnt[1]), .pad_count(pad_cnt[1]), .drop_count(drop_cnt[1]));

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endfunction

  // ---------------- reference model ----------------
  logic [63:0] exp0[$];
  logic [63:0] exp1[$];
  int          m_cnt  [2] = '{0, 0};
  logic [7:0]  m_bytes[2][8];
  int          m_pad  [2] = '{0, 0};
  int          m_drop [2] = '{0, 0};

  function automatic logic [63:0] pack_block(int idx);
    logic [63:0] r = '0;
    for (int i = 0; i < 8; i++) r = r | (64'(m_bytes[idx][i]) << (8 * (7 - i)));
    return r;
  endfunction

  function automatic void push_exp(int idx, logic [63:0] v);
    if (idx == 0) exp0.push_back(v); else exp1.push_back(v);
  endfunction

  function automatic void model_byte(int idx, logic [7:0] b);
    m_bytes[idx][m_cnt[idx]] = b;
    m_cnt[idx]++;
    if (m_cnt[idx] == 8) begin
      push_exp(idx, pack_block(idx));
      m_cnt[idx] = 0;
    end
  endfunction

  // Partial block timed out: instance 0 pads, instance 1 drops.
  function automatic void model_timeout(int idx);
    if (idx == 0) begin
      for (int i = m_cnt[idx]; i < 8; i++) m_bytes[idx][i] = 8'hAA;
      push_exp(idx, pack_block(idx));
      if (m_pad[idx] < 65535) m_pad[idx]++;
    end else begin
      if (m_drop[idx] < 65535) m_drop[idx]++;
    end
    m_cnt[idx] = 0;
  endfunction

  function automatic void model_reset(int idx);
    if (idx == 0) exp0.delete(); else exp1.delete();
    m_cnt[idx]  = 0;
    m_pad[idx]  = 0;
    m_drop[idx] = 0;
  endfunction

  // ---------------- sink backpressure ----------------
  int bp_mode[2] = '{1, 1};  // 0 = hold low, 1 = hold high, 2 = random
  always begin
    for (int i = 0; i < 2; i++)
      m_tready[i] = (bp_mode[i] == 2) ? (($urandom % 4) != 0) : (bp_mode[i] == 1);
    @(posedge clk);
    #1;
  end

  // ---------------- monitor / scoreboard ----------------
  logic        prev_v[2] = '{1'b0, 1'b0};
  logic        prev_r[2];
  logic [63:0] prev_d[2];

  function automatic void mon(int idx);
    logic [63:0] e;
    if (rst_n[idx] !== 1'b1) begin
      prev_v[idx] = 1'b0;
      return;
    end
    if (prev_v[idx] && !prev_r[idx]) begin
      chk("hold_valid", 64'(m_tvalid[idx]), 64'd1);
      chk("hold_data", m_tdata[idx], prev_d[idx]);
    end
    if (m_tvalid[idx]) chk("s_ready_low_while_valid", 64'(s_tready[idx]), 64'd0);
    if (m_tvalid[idx] && m_tready[idx]) begin
      if ((idx == 0 && exp0.size() == 0) || (idx == 1 && exp1.size() == 0)) begin
        n_checks++;
        $display("FAIL unexpected_block dut%0d: got 0x%0h, expected no block", idx, m_tdata[idx]);
      end else begin
        e = (idx == 0) ? exp0.pop_front() : exp1.pop_front();
        chk("block", m_tdata[idx], e);
      end
    end
    prev_v[idx] = m_tvalid[idx];
    prev_r[idx] = m_tready[idx];
    prev_d[idx] = m_tdata[idx];
  endfunction

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int idx, int n);
    if (m_cnt[idx] > 0 && n >= TO) model_timeout(idx);
    s_tvalid[idx] = 1'b0;
    repeat (n) step();
  endtask

  task automatic send_byte(int idx, logic [7:0] b, int gap);
    bit acc;
    int guard;
    idle(idx, gap);
    model_byte(idx, b);
    s_tvalid[idx] = 1'b1;
    s_tdata[idx]  = b;
    guard = 0;
    acc   = 1'b0;
    do begin
      @(negedge clk);
      acc = s_tready[idx];
      step();
      guard++;
    end while (!acc && guard < 500);
    if (!acc) chk("byte_accept_timeout", 64'd0, 64'd1);
    s_tvalid[idx] = 1'b0;
  endtask

  task automatic rst_pulse(int idx);
    rst_n[idx] = 1'b0;
    model_reset(idx);
    step();
    rst_n[idx] = 1'b1;
    chk("rst_m_valid", 64'(m_tvalid[idx]), 64'd0);
    chk("rst_byte_cnt", 64'(byte_cnt[idx]), 64'd0);
    chk("rst_s_ready", 64'(s_tready[idx]), 64'd1);
    chk("rst_pad_count", 64'(pad_cnt[idx]), 64'd0);
    chk("rst_drop_count", 64'(drop_cnt[idx]), 64'd0);
  endtask

  task automatic rand_phase(int idx);
    int gaps[8] = '{0, 0, 1, 3, 15, 16, 17, 25};
    for (int k = 0; k < 80; k++)
      send_byte(idx, 8'($urandom), gaps[$urandom % 8]);
    idle(idx, 30);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; s_tvalid[i] = 1'b0; s_tdata[i] = '0;
    end
    repeat (3) step();
    for (int i = 0; i < 2; i++) rst_n[i] = 1'b1;

    // Reset state
    for (int i = 0; i < 2; i++) begin
      chk("reset_s_ready", 64'(s_tready[i]), 64'd1);
      chk("reset_m_valid", 64'(m_tvalid[i]), 64'd0);
      chk("reset_m_data", m_tdata[i], 64'd0);
      chk("reset_byte_cnt", 64'(byte_cnt[i]), 64'd0);
      chk("reset_pad", 64'(pad_cnt[i]), 64'd0);
      chk("reset_drop", 64'(drop_cnt[i]), 64'd0);
    end

    // Test 1: eight back-to-back bytes
    for (int b = 1; b <= 8; b++) send_byte(0, 8'(b), 0);
    chk("t1_valid_after_byte8", 64'(m_tvalid[0]), 64'd1);
    chk("t1_ready_low", 64'(s_tready[0]), 64'd0);
    chk("t1_byte_cnt_full", 64'(byte_cnt[0]), 64'd8);
    chk("t1_data", m_tdata[0], 64'h0102030405060708);
    step();
    chk("t1_valid_dropped", 64'(m_tvalid[0]), 64'd0);
    chk("t1_ready_back", 64'(s_tready[0]), 64'd1);
    chk("t1_pad_count", 64'(pad_cnt[0]), 64'd0);

    // Test 2: sixteen bytes with 20 cycles of backpressure on block 1
    bp_mode[0] = 0;
    fork
      for (int i = 0; i < 16; i++) send_byte(0, 8'(16 + i), 0);
      begin
        int g = 0;
        while (!m_tvalid[0] && g < 200) begin step(); g++; end
        chk("t2_block1_valid", 64'(m_tvalid[0]), 64'd1);
        repeat (20) step();
        chk("t2_ready_held_low", 64'(s_tready[0]), 64'd0);
        chk("t2_block1_held", m_tdata[0], 64'h1011121314151617);
        bp_mode[0] = 1;
      end
    join
    idle(0, 5);
    chk("t2_queue_empty", 64'(exp0.size()), 64'd0);

    // Test 3: three bytes then timeout with padding
    send_byte(0, 8'hC1, 0);
    send_byte(0, 8'hC2, 0);
    send_byte(0, 8'hC3, 0);
    model_timeout(0);
    repeat (15) step();
    chk("t3_no_timeout_at_15", 64'(s_tready[0]), 64'd1);
    chk("t3_byte_cnt_3", 64'(byte_cnt[0]), 64'd3);
    step();
    chk("t3_pad_entry", 64'(s_tready[0]), 64'd0);
    chk("t3_no_valid_in_pad", 64'(m_tvalid[0]), 64'd0);
    repeat (4) step();
    chk("t3_still_padding", 64'(m_tvalid[0]), 64'd0);
    step();
    chk("t3_valid_after_5_pad", 64'(m_tvalid[0]), 64'd1);
    chk("t3_data", m_tdata[0], 64'hC1C2C3AAAAAAAAAA);
    chk("t3_pad_count", 64'(pad_cnt[0]), 64'd1);
    idle(0, 3);

    // Test 5: gaps of 14 and 15 idle cycles never time out
    send_byte(0, 8'h31, 0);
    for (int i = 1; i < 8; i++) send_byte(0, 8'(8'h31 + i), (i == 3) ? 14 : 15);
    idle(0, 3);
    chk("t5_pad_count_unchanged", 64'(pad_cnt[0]), 64'd1);
    chk("t5_byte_cnt", 64'(byte_cnt[0]), 64'd0);
    chk("t5_queue_empty", 64'(exp0.size()), 64'd0);

    // Test 4: discard mode
    for (int i = 0; i < 5; i++) send_byte(1, 8'(8'h70 + i), 0);
    idle(1, 20);
    chk("t4_byte_cnt_cleared", 64'(byte_cnt[1]), 64'd0);
    chk("t4_drop_count", 64'(drop_cnt[1]), 64'd1);
    chk("t4_s_ready", 64'(s_tready[1]), 64'd1);
    for (int i = 0; i < 8; i++) send_byte(1, 8'(8'h21 + i), 0);
    idle(1, 3);
    chk("t4_queue_empty", 64'(exp1.size()), 64'd0);
    send_byte(1, 8'h99, 0);
    model_timeout(1);
    repeat (15) step();
    chk("t4_edge_cnt_at_15", 64'(byte_cnt[1]), 64'd1);
    step();
    chk("t4_edge_cnt_at_16", 64'(byte_cnt[1]), 64'd0);
    chk("t4_edge_drop", 64'(drop_cnt[1]), 64'd2);

    // Test 6: reset during OUT, then during PAD
    bp_mode[0] = 0;
    for (int i = 0; i < 8; i++) send_byte(0, 8'(8'h41 + i), 0);
    step();
    chk("t6_in_out", 64'(m_tvalid[0]), 64'd1);
    rst_pulse(0);
    bp_mode[0] = 1;
    for (int i = 0; i < 3; i++) send_byte(0, 8'(8'h51 + i), 0);
    repeat (17) step();
    chk("t6_in_pad_ready", 64'(s_tready[0]), 64'd0);
    chk("t6_in_pad_cnt", 64'(byte_cnt[0]), 64'd4);
    rst_pulse(0);
    for (int i = 0; i < 8; i++) send_byte(0, 8'(8'h61 + i), 0);
    idle(0, 3);
    chk("t6_clean_block_done", 64'(exp0.size()), 64'd0);

    // Randomized traffic with random backpressure on both instances
    bp_mode[0] = 2;
    bp_mode[1] = 2;
    fork
      rand_phase(0);
      rand_phase(1);
    join
    bp_mode[0] = 1;
    bp_mode[1] = 1;
    repeat (60) step();
    for (int i = 0; i < 2; i++) begin
      chk("final_queue_empty", 64'((i == 0) ? exp0.size() : exp1.size()), 64'd0);
      chk("final_pad_count", 64'(pad_cnt[i]), 64'(m_pad[i]));
      chk("final_drop_count", 64'(drop_cnt[i]), 64'(m_drop[i]));
      chk("final_byte_cnt", 64'(byte_cnt[i]), 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
